// File: rtl/spi_fifo_pkg.sv
// spi_fifo_pkg: shared types and constants for the SPI FIFO read path.
//   rd_state_t  - read scheduler state encoding
//   BURST_CNT_W - width of the completed-burst counter
//   DEF_*       - default parameter values for spi_fifo_rd_ctrl
//   cnt_w()     - counter width able to hold 0..n (never less than 1 bit)
package spi_fifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STARTUP,
        ST_WAIT_DATA,
        ST_BURST_HI,
        ST_BURST_LO,
        ST_GAP
    } rd_state_t;

    localparam int BURST_CNT_W   = 16;

    localparam int DEF_DIV       = 4;
    localparam int DEF_BURST_LEN = 16;
    localparam int DEF_STARTUP   = 10000;
    localparam int DEF_GAP_CYC   = 64;

    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spi_fifo_clk_div.sv
// spi_fifo_clk_div: phase timer for the serial clock.
//   clk_in - clock
//   rst    - asynchronous active-high reset
//   run    - count while high; low parks the timer at the start of a high half
//   fall   - strobe in the last cycle of a high half (sck should drop next)
//   rise   - strobe in the last cycle of a low half (sck should rise next)
// Each half lasts DIV cycles. The strobes are combinational; the consumer
// registers sck from them.
module spi_fifo_clk_div
    import spi_fifo_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic clk_in,
    input  logic rst,
    input  logic run,
    output logic rise,
    output logic fall
);

    localparam int            CW   = cnt_w(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;   // 0: high half, 1: low half
    logic          wrap;

    always_comb begin
        wrap    = (cnt_q == LAST);
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!run) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (wrap) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign fall = run & wrap & ~phase_q;
    assign rise = run & wrap &  phase_q;

endmodule

// File: rtl/spi_fifo_rd_ctrl.sv
// spi_fifo_rd_ctrl: read-side burst scheduler for the SPI FIFO path.
//   clk_in, rst  - clock, asynchronous active-high reset
//   en           - enable; dropping it lets the current burst finish
//   fifo_aempty  - low: a full burst is available (sampled in WAIT_DATA only)
//   fifo_empty   - FIFO empty (used only with SPI_FIFO_RD_CTRL_UNDERRUN_EN)
//   fifo_re      - one-cycle read strobe, coincident with each sck rise
//   sck          - serial clock, half-period DIV cycles, low when idle
//   busy         - high during BURST_HI / BURST_LO
//   burst_done   - one-cycle pulse on entry to GAP
//   burst_cnt    - completed bursts, wraps
//   underrun     - sticky; port present only with SPI_FIFO_RD_CTRL_UNDERRUN_EN
// Optional feature macro: SPI_FIFO_RD_CTRL_UNDERRUN_EN. When defined, a read
// point that finds the FIFO empty suppresses the read and ends the burst.
// All outputs are registered.
module spi_fifo_rd_ctrl
    import spi_fifo_pkg::*;
#(
    parameter int DIV       = DEF_DIV,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int STARTUP   = DEF_STARTUP,
    parameter int GAP_CYC   = DEF_GAP_CYC
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   fifo_aempty,
    input  logic                   fifo_empty,
    output logic                   fifo_re,
    output logic                   sck,
    output logic                   busy,
    output logic                   burst_done,
    output logic [BURST_CNT_W-1:0] burst_cnt
`ifdef SPI_FIFO_RD_CTRL_UNDERRUN_EN
    ,
    output logic                   underrun
`endif
);

    localparam int SU_W = cnt_w(STARTUP);
    localparam int GP_W = cnt_w(GAP_CYC);
    localparam int WT_W = (SU_W > GP_W) ? SU_W : GP_W;
    localparam int PC_W = cnt_w(BURST_LEN);

    // STARTUP and GAP share one wait counter; each compares against its
    // last cycle index. GAP_CYC=0 still spends one cycle in GAP.
    localparam logic [WT_W-1:0] SU_LAST = WT_W'((STARTUP > 0) ? STARTUP - 1 : 0);
    localparam logic [WT_W-1:0] GP_LAST = WT_W'((GAP_CYC > 1) ? GAP_CYC - 1 : 0);
    localparam logic [PC_W-1:0] PC_MAX  = PC_W'(BURST_LEN);

    rd_state_t              state_q, state_d;
    logic [WT_W-1:0]        wait_cnt_q, wait_cnt_d;
    logic [PC_W-1:0]        pulse_cnt_q, pulse_cnt_d;
    logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic                   sck_q, sck_d;
    logic                   fifo_re_q, fifo_re_d;
    logic                   busy_q, busy_d;
    logic                   burst_done_q, burst_done_d;
    logic                   rise, fall;
    logic                   start_pulse, end_burst, read_blocked;

`ifdef SPI_FIFO_RD_CTRL_UNDERRUN_EN
    logic underrun_q, underrun_d;
    assign read_blocked = fifo_empty;
`else
    logic unused_fifo_empty;
    assign unused_fifo_empty = fifo_empty;
    assign read_blocked      = 1'b0;
`endif

    spi_fifo_clk_div #(.DIV(DIV)) u_clk_div (
        .clk_in (clk_in),
        .rst    (rst),
        .run    (busy_q),
        .rise   (rise),
        .fall   (fall)
    );

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        pulse_cnt_d  = pulse_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        sck_d        = sck_q;
        fifo_re_d    = 1'b0;
        burst_done_d = 1'b0;
        start_pulse  = 1'b0;
        end_burst    = 1'b0;
`ifdef SPI_FIFO_RD_CTRL_UNDERRUN_EN
        underrun_d   = underrun_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d    = ST_STARTUP;
                    wait_cnt_d = '0;
                end
            end
            ST_STARTUP: begin
                // Leaving via IDLE clears the counter on re-entry, so a
                // toggle of en restarts the whole delay.
                if (!en)                       state_d = ST_IDLE;
                else if (wait_cnt_q >= SU_LAST) state_d = ST_WAIT_DATA;
                else                            wait_cnt_d = wait_cnt_q + 1'b1;
            end
            ST_WAIT_DATA: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (!fifo_aempty) begin
                    start_pulse = 1'b1;
                    pulse_cnt_d = '0;
                end
            end
            ST_BURST_HI: begin
                if (fall) begin
                    state_d = ST_BURST_LO;
                    sck_d   = 1'b0;
                end
            end
            ST_BURST_LO: begin
                if (rise) begin
                    if (pulse_cnt_q < PC_MAX) start_pulse = 1'b1;
                    else                      end_burst   = 1'b1;
                end
            end
            ST_GAP: begin
                if (wait_cnt_q >= GP_LAST) state_d = en ? ST_WAIT_DATA : ST_IDLE;
                else                       wait_cnt_d = wait_cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Each read point: rise sck and strobe the FIFO, unless an empty FIFO
        // blocks the read, which ends the burst early.
        if (start_pulse) begin
            if (read_blocked) begin
                end_burst = 1'b1;
`ifdef SPI_FIFO_RD_CTRL_UNDERRUN_EN
                underrun_d = 1'b1;
`endif
            end else begin
                state_d     = ST_BURST_HI;
                sck_d       = 1'b1;
                fifo_re_d   = 1'b1;
                pulse_cnt_d = pulse_cnt_d + 1'b1;
            end
        end

        if (end_burst) begin
            state_d      = ST_GAP;
            sck_d        = 1'b0;
            wait_cnt_d   = '0;
            burst_done_d = 1'b1;
            burst_cnt_d  = burst_cnt_q + 1'b1;
        end

        busy_d = (state_d == ST_BURST_HI) || (state_d == ST_BURST_LO);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= '0;
            pulse_cnt_q  <= '0;
            burst_cnt_q  <= '0;
            sck_q        <= 1'b0;
            fifo_re_q    <= 1'b0;
            busy_q       <= 1'b0;
            burst_done_q <= 1'b0;
`ifdef SPI_FIFO_RD_CTRL_UNDERRUN_EN
            underrun_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            pulse_cnt_q  <= pulse_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            sck_q        <= sck_d;
            fifo_re_q    <= fifo_re_d;
            busy_q       <= busy_d;
            burst_done_q <= burst_done_d;
`ifdef SPI_FIFO_RD_CTRL_UNDERRUN_EN
            underrun_q   <= underrun_d;
`endif
        end
    end

    assign fifo_re    = fifo_re_q;
    assign sck        = sck_q;
    assign busy       = busy_q;
    assign burst_done = burst_done_q;
    assign burst_cnt  = burst_cnt_q;
`ifdef SPI_FIFO_RD_CTRL_UNDERRUN_EN
    assign underrun   = underrun_q;
`endif

endmodule

// File: doc/spi_fifo_rd_ctrl.md
# spi_fifo_rd_ctrl

Read-side scheduler for the SPI FIFO path. After a power-up settling delay, it watches the FIFO almost-empty flag. It then drains data in fixed-length bursts: one FIFO read strobe per serial clock pulse, with an idle gap between bursts. It replaces free-running gated read clocks with a single-clock FSM that drives `fifo_re` and `sck` as registered outputs.

## Interface
- `DIV`, 4: `sck` half-period in `clk_in` cycles; must be ≥1.
- `BURST_LEN`, 16: `sck` pulses (and FIFO reads) per burst; must be ≥1.
- `STARTUP`, 10000: cycles to wait after reset or `en` rising before the first burst.
- `GAP_CYC`, 64: idle cycles between bursts; 0 is allowed.
- `clk_in` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: enable. Low forces IDLE once any current burst completes.
- `fifo_aempty` in 1: FIFO almost-empty. Low means a full burst is available.
- `fifo_empty` in 1: FIFO empty.
- `fifo_re` out 1: one-cycle read strobe to the FIFO.
- `sck` out 1: serial clock, low when idle.
- `busy` out 1: high in the BURST_HI and BURST_LO states.
- `burst_done` out 1: one-cycle pulse when a burst ends.
- `burst_cnt` out 16: completed bursts; wraps 0xFFFF→0.
- `underrun` out 1: sticky; present only with the macro.

## Operation
- States: IDLE, STARTUP, WAIT_DATA, BURST_HI, BURST_LO, GAP.
- Reset: all outputs 0; state IDLE; all counters 0.
- IDLE→STARTUP when `en`=1. The startup counter clears on entry.
- STARTUP→WAIT_DATA after `STARTUP` cycles.
- WAIT_DATA→BURST_HI when `fifo_aempty`=0 and `en`=1. WAIT_DATA→IDLE when `en`=0.
- BURST_HI: `sck`=1 for `DIV` cycles. `fifo_re` is high only in the first cycle.
- BURST_LO: `sck`=0 for `DIV` cycles, then:
  - pulse count < `BURST_LEN`: back to BURST_HI.
  - otherwise: GAP.
- GAP: `burst_done` pulses in the entry cycle; `burst_cnt` increments. After `GAP_CYC` cycles:
  - `en`=1: go to WAIT_DATA.
  - `en`=0: go to IDLE.
  - `GAP_CYC`=0: GAP lasts exactly one cycle.
- `en` falling mid-burst: the burst completes normally; there are no truncated bursts.
- `en` toggling in STARTUP: returning to IDLE restarts the full delay.
- `fifo_aempty` changes during a burst: ignored; it is sampled only in WAIT_DATA.
- `rst` mid-burst: `sck` and `fifo_re` drop immediately (asynchronously); `burst_cnt` clears.
- Counter widths: `$clog2(param+1)`. Comparisons are unsigned.

## Timing
- All outputs are registered.
- WAIT_DATA→BURST_HI transition at edge E:
  - `sck`↑ and `fifo_re`↑ at E.
  - `fifo_re`↓ at E+1.
  - `sck`↓ at E+DIV.
  - next `sck`↑ at E+2·DIV.
- Burst length is 2·DIV·BURST_LEN cycles. `burst_done` is high in the cycle after the last `sck` low phase.
- Burst-to-burst minimum: 2·DIV·BURST_LEN + max(GAP_CYC,1) + 1 cycles (the +1 is the WAIT_DATA evaluation cycle).
- With `DIV`=1: `fifo_re` and `sck` are high together for one cycle each pulse.

## Configuration
- Macro: `SPI_FIFO_RD_CTRL_UNDERRUN_EN`.
- Defined:
  - At each read point in BURST_HI entry, if `fifo_empty`=1, `fifo_re` is suppressed.
  - `underrun` is set (sticky until `rst`).
  - The FSM jumps straight to GAP, with `burst_done` pulsed and `burst_cnt` incremented.
- Undefined:
  - The `underrun` port is absent.
  - `fifo_empty` is unused.
  - `fifo_re` is issued unconditionally; the FIFO ignores reads while empty.

## Structure
- Package `spi_fifo_pkg`:
  - state enum `rd_state_t`.
  - `BURST_CNT_W`=16.
  - default parameter constants.
- Sub-module `spi_fifo_clk_div`:
  - inputs: `clk_in`, `rst`, `run`.
  - outputs: `rise`/`fall` strobes every `DIV` cycles.
  - the FSM consumes the strobes to set/clear `sck`.

## Test plan
- Parameters for all scenarios: DIV=2, BURST_LEN=4, STARTUP=8, GAP_CYC=3.
- Reset release, `en`=1, `fifo_aempty`=0 at cycle 0 → first `sck`↑/`fifo_re` at cycle 9 (8 STARTUP cycles + 1 WAIT_DATA evaluation cycle); 4 `fifo_re` pulses 4 cycles apart; `burst_done` at cycle 25; `burst_cnt`=1.
- `fifo_aempty` held low → next burst `sck`↑ 4 cycles after `burst_done` (3 GAP + 1 WAIT_DATA); `burst_cnt`=2.
- `en`↓ during the second `sck` pulse → the burst still delivers 4 reads, then IDLE; `busy`=0, `sck`=0.
- `rst` pulse mid-BURST_HI → `sck`, `fifo_re`, `busy`, `burst_cnt` all 0 asynchronously; after release, the full STARTUP delay is repeated.
- Macro on: `fifo_empty`=1 before the third read → only 2 `fifo_re` pulses; `underrun`=1 and stays 1; `burst_done` pulses; `burst_cnt` increments.
- Force `burst_cnt`=0xFFFF, complete one burst → `burst_cnt`=0x0000.
